// File: rtl/alu_flags_stage.sv
// ============================================================================
//  Module   : alu_flags_stage
//  Purpose  : Registered result/NZCV output stage behind the adder/subtractor.
//             It has a 2-entry skid buffer, so in_ready_o is registered.
//  Options  : ALU_STICKY_OVF_EN adds a sticky overflow flag (sticky_v_o/clr_sticky_i)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_flags_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic         in_op_i,
  input  logic         in_a_msb_i,
  input  logic         in_b_msb_i,
  input  logic [W-1:0] in_r_i,
  input  logic         in_carry_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_r_o,
  output logic [3:0]   out_flags_o
`ifdef ALU_STICKY_OVF_EN
  ,
  output logic         sticky_v_o,
  input  logic         clr_sticky_i
`endif
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_r_q, out_r_d;
  logic [3:0]   out_flags_q, out_flags_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_r_q, skid_r_d;
  logic [3:0]   skid_flags_q, skid_flags_d;

  logic         w_accept;
  logic         w_n, w_z, w_v;
  logic [3:0]   w_flags;

  assign in_ready_o  = ~skid_valid_q;
  assign w_accept    = in_valid_i & in_ready_o;
  assign out_valid_o = out_valid_q;
  assign out_r_o     = out_r_q;
  assign out_flags_o = out_flags_q;

  // C is the adder's carry-out as-is; V follows the operand/result sign rule.
  assign w_n     = in_r_i[W-1];
  assign w_z     = (in_r_i == '0);
  assign w_v     = in_op_i ? ((in_a_msb_i != in_b_msb_i) && (w_n != in_a_msb_i))
                           : ((in_a_msb_i == in_b_msb_i) && (w_n != in_a_msb_i));
  assign w_flags = {w_n, w_z, in_carry_i, w_v};

  always_comb begin
    out_valid_d  = out_valid_q;
    out_r_d      = out_r_q;
    out_flags_d  = out_flags_q;
    skid_valid_d = skid_valid_q;
    skid_r_d     = skid_r_q;
    skid_flags_d = skid_flags_q;
    if (!out_valid_q || out_ready_i) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_r_d      = skid_r_q;
        out_flags_d  = skid_flags_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        out_valid_d = 1'b1;
        out_r_d     = in_r_i;
        out_flags_d = w_flags;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_r_d     = in_r_i;
      skid_flags_d = w_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_r_q      <= '0;
      out_flags_q  <= 4'b0000;
      skid_valid_q <= 1'b0;
      skid_r_q     <= '0;
      skid_flags_q <= 4'b0000;
    end else begin
      out_valid_q  <= out_valid_d;
      out_r_q      <= out_r_d;
      out_flags_q  <= out_flags_d;
      skid_valid_q <= skid_valid_d;
      skid_r_q     <= skid_r_d;
      skid_flags_q <= skid_flags_d;
    end
  end

  // A full skid deasserts in_ready, so skid drain and accept never coincide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(skid_valid_q && w_accept))
        else $error("skid drain coincided with accept");
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set has priority over clear so an overflow in the clearing cycle is kept.
  assign sticky_d   = (sticky_q & ~clr_sticky_i) | (w_accept & w_v);
  assign sticky_v_o = sticky_q;

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_flags_stage.sv
// ============================================================================
//  Module   : tb_alu_flags_stage
//  Purpose  : Self-checking bench for alu_flags_stage (scoreboard queue).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_flags_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_op, in_a_msb, in_b_msb, in_carry;
  logic [W-1:0] in_r;
  logic         out_valid, out_ready;
  logic [W-1:0] out_r;
  logic [3:0]   out_flags;
`ifdef ALU_STICKY_OVF_EN
  logic         sticky_v, clr_sticky;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_flags_stage #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_a_msb_i  (in_a_msb),
    .in_b_msb_i  (in_b_msb),
    .in_r_i      (in_r),
    .in_carry_i  (in_carry),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_r_o     (out_r),
    .out_flags_o (out_flags)
`ifdef ALU_STICKY_OVF_EN
    ,
    .sticky_v_o  (sticky_v),
    .clr_sticky_i(clr_sticky)
`endif
  );

  // Reference NZCV from the sign-bit overflow rule.
  function automatic logic [3:0] model_flags(input logic op, input logic a, input logic b,
                                             input logic [W-1:0] r, input logic c);
    logic n, z, v;
    n = r[W-1];
    z = (r == '0);
    v = op ? ((a != b) && (n != a)) : ((a == b) && (n != a));
    return {n, z, c, v};
  endfunction

  task automatic drive(input logic v, input logic op, input logic a, input logic b,
                       input logic [W-1:0] r, input logic c);
    in_valid = v; in_op = op; in_a_msb = a; in_b_msb = b; in_r = r; in_carry = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_r !== '0) begin miscompares++; $display("FAIL reset_out_r: got %h expected 0", out_r); end
    vectors++; if (out_flags !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b expected 0000", out_flags); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    out_ready = 1'b1;
    // 0x7FFFFFFF + 1
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    // 5 - 5
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    vectors++; if (out_valid !== 1'b1 || out_r !== 32'h8000_0000 || out_flags !== 4'b1001) begin
      miscompares++; $display("FAIL add_ovf: got v=%b r=%h f=%b expected v=1 r=80000000 f=1001", out_valid, out_r, out_flags);
    end
    @(posedge clk); #1;
    // 0x80000000 - 1
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1);
    vectors++; if (out_valid !== 1'b1 || out_r !== 32'h0 || out_flags !== 4'b0110) begin
      miscompares++; $display("FAIL sub_zero: got v=%b r=%h f=%b expected v=1 r=00000000 f=0110", out_valid, out_r, out_flags);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    vectors++; if (out_valid !== 1'b1 || out_r !== 32'h7FFF_FFFF || out_flags !== 4'b0011) begin
      miscompares++; $display("FAIL sub_ovf: got v=%b r=%h f=%b expected v=1 r=7fffffff f=0011", out_valid, out_r, out_flags);
    end
    @(posedge clk); #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arith_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int   sent = 0;
    exp_t e;
    logic [W-1:0] r;
    for (int cyc = 0; cyc < 30 && (sent < 3 || sb.size() > 0); cyc++) begin
      out_ready = (cyc >= 3);
      r = 32'h0000_0100 + sent;
      if (sent < 3) drive(1'b1, sent[0], 1'b1, sent[1], r, sent[0]);
      else          drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      if (cyc == 2) begin
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      end
      if (cyc == 1 || cyc == 2) begin
        vectors++; if (out_valid !== 1'b1 || out_r !== 32'h100) begin
          miscompares++; $display("FAIL bp_hold: got v=%b r=%h expected v=1 r=00000100", out_valid, out_r);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL bp_extra: got r=%h expected none", out_r);
        end else begin
          e = sb.pop_front();
          if (out_r !== e.r || out_flags !== e.f) begin
            miscompares++; $display("FAIL bp_data: got r=%h f=%b expected r=%h f=%b", out_r, out_flags, e.r, e.f);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back('{r: in_r, f: model_flags(in_op, in_a_msb, in_b_msb, in_r, in_carry)});
        sent++;
      end
      @(posedge clk); #1;
    end
    vectors++; if (sent != 3 || sb.size() != 0) begin
      miscompares++; $display("FAIL bp_drain: got sent=%0d pending=%0d expected sent=3 pending=0", sent, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int   got = 0;
    exp_t e;
    logic [W-1:0] r;
    out_ready = 1'b1;
    for (int i = 0; i < 102; i++) begin
      r = i[31:0] ^ (i[4] ? 32'h8000_0000 : 32'h0);
      if (i < 100) drive(1'b1, i[0], i[1], i[2], r, i[0] & i[3]);
      else         drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      if (i < 100 && in_ready !== 1'b1) begin
        vectors++; miscompares++; $display("FAIL b2b_in_ready: cycle %0d got %b expected 1", i, in_ready);
      end
      if (i >= 1 && i <= 100) begin
        vectors++;
        if (!out_valid) begin
          miscompares++; $display("FAIL b2b_bubble: cycle %0d got out_valid=0 expected 1", i);
        end else if (sb.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra: got r=%h expected none", out_r);
        end else begin
          e = sb.pop_front(); got++;
          if (out_r !== e.r || out_flags !== e.f) begin
            miscompares++; $display("FAIL b2b_data: got r=%h f=%b expected r=%h f=%b", out_r, out_flags, e.r, e.f);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{r: in_r, f: model_flags(in_op, in_a_msb, in_b_msb, in_r, in_carry)});
      @(posedge clk); #1;
    end
    vectors++; if (got != 100 || sb.size() != 0) begin
      miscompares++; $display("FAIL b2b_count: got %0d outputs pending=%0d expected 100 pending=0", got, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hA000 + i, 1'b0);
      @(posedge clk); #1;
    end
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_full: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_r !== '0) begin
      miscompares++; $display("FAIL mid_reset: got v=%b rdy=%b r=%h expected v=0 rdy=1 r=0", out_valid, in_ready, out_r);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      vectors++; if (out_valid !== 1'b0) begin
        miscompares++; $display("FAIL mid_stale: cycle %0d got out_valid=%b r=%h expected 0", i, out_valid, out_r);
      end
    end
  endtask

`ifdef ALU_STICKY_OVF_EN
  task automatic test_sticky();
    out_ready = 1'b1; clr_sticky = 1'b0;
    vectors++; if (sticky_v !== 1'b0) begin miscompares++; $display("FAIL sticky_init: got %b expected 0", sticky_v); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0003, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0001, 1'b1);
    @(posedge clk); #1;
    vectors++; if (sticky_v !== 1'b1) begin miscompares++; $display("FAIL sticky_hold: got %b expected 1", sticky_v); end
    clr_sticky = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0);
    @(posedge clk); #1;
    vectors++; if (sticky_v !== 1'b1) begin miscompares++; $display("FAIL sticky_clr_set: got %b expected 1", sticky_v); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    vectors++; if (sticky_v !== 1'b0) begin miscompares++; $display("FAIL sticky_clr: got %b expected 0", sticky_v); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 1'b0;
`endif
    test_reset();
    @(posedge clk); #1;
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
`ifdef ALU_STICKY_OVF_EN
    test_sticky();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
